dram_device_model: RTL and testbench

- Cycle-accurate behavioural DRAM device. It is the responder on the DRAM pin interface that the DRAM wrapper drives.
- Decodes row activate, precharge and column read/write commands, and enforces tRCD, tRP and CAS latency.
- Returns read data with a one-cycle valid strobe and flags protocol violations.
- Used as the memory in system-level simulation and as the device-side golden model for wrapper verification.

---
 rtl/dram_device_model.sv | 156 +++++++++++++++
 tb/tb_dram_device_model.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dram_device_model.sv
// Cycle-accurate behavioural DRAM device: decodes ACT/PRE/column commands, enforces
// tRCD/tRP, returns reads after CAS latency and flags protocol violations.
module dram_device_model #(
  parameter int T_RCD         = 2,
  parameter int T_RP          = 2,
  parameter int CL            = 3,
  parameter int MEM_ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DRAM_CSn,
  input  logic        DRAM_RASn,
  input  logic        DRAM_CASn,
  input  logic [3:0]  DRAM_WEn,
  input  logic [10:0] DRAM_A,
  input  logic [31:0] DRAM_D,
  output logic [31:0] DRAM_Q,
  output logic        DRAM_valid,
  output logic        DRAM_err
);

  typedef enum logic [1:0] {IDLE, ACT_WAIT, ACTIVE, PRE_WAIT} state_t;

  localparam int CNT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ras_prev_q, ras_prev_d;
  logic [10:0]              row_q, row_d;
  logic                     err_q, err_d;
  logic [CL-1:0]            rd_vld_q, rd_vld_d;
  logic [31:0]              rd_data_q [CL];
  logic [31:0]              rd_data_d [CL];
  logic [31:0]              mem_q [2**MEM_ADDR_BITS];

  logic                     cmd_en, is_act, is_pre, is_col, is_wr;
  logic                     illegal, wr_en, rd_en;
  logic [MEM_ADDR_BITS-1:0] idx;

  // Command decode: RAS edges relative to the last selected cycle distinguish ACT from PRE
  always_comb begin
    cmd_en     = ~DRAM_CSn;
    is_act     = cmd_en & ~DRAM_RASn & ras_prev_q;
    is_pre     = cmd_en & DRAM_RASn & ~ras_prev_q;
    is_col     = cmd_en & ~DRAM_RASn & ~ras_prev_q & ~DRAM_CASn;
    is_wr      = is_col & (DRAM_WEn != 4'hF);
    ras_prev_d = cmd_en ? DRAM_RASn : ras_prev_q;
    idx        = MEM_ADDR_BITS'({row_q, DRAM_A[9:0]});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    illegal = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_act) begin
          row_d = DRAM_A;
          if (T_RCD == 1) begin
            state_d = ACTIVE;
          end else begin
            state_d = ACT_WAIT;
            cnt_d   = CNT_W'(T_RCD - 1);
          end
        end else if (is_col) begin
          illegal = 1'b1;
        end
      end
      ACT_WAIT: begin
        if (is_pre) begin
          if (T_RP == 1) begin
            state_d = IDLE;
          end else begin
            state_d = PRE_WAIT;
            cnt_d   = CNT_W'(T_RP - 1);
          end
        end else begin
          illegal = is_act | is_col;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (is_pre) begin
          if (T_RP == 1) begin
            state_d = IDLE;
          end else begin
            state_d = PRE_WAIT;
            cnt_d   = CNT_W'(T_RP - 1);
          end
        end else if (is_act) begin
          illegal = 1'b1;
        end else begin
          wr_en = is_wr;
          rd_en = is_col & ~is_wr;
        end
      end
      PRE_WAIT: begin
        illegal = is_act | is_col;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q | illegal;
  end

  // Read pipeline: stage 0 samples the array, data only moves with its valid so the
  // final stage holds the last returned word between strobes
  always_comb begin
    rd_vld_d[0]  = rd_en;
    rd_data_d[0] = rd_en ? mem_q[idx] : rd_data_q[0];
    for (int k = 1; k < CL; k++) begin
      rd_vld_d[k]  = rd_vld_q[k-1];
      rd_data_d[k] = rd_vld_q[k-1] ? rd_data_q[k-1] : rd_data_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ras_prev_q <= 1'b1;
      row_q      <= '0;
      err_q      <= 1'b0;
      rd_vld_q   <= '0;
      for (int k = 0; k < CL; k++) rd_data_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ras_prev_q <= ras_prev_d;
      row_q      <= row_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_vld_d;
      for (int k = 0; k < CL; k++) rd_data_q[k] <= rd_data_d[k];
    end
  end

  // Storage is never reset; byte lanes with WEn low are written
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (!DRAM_WEn[b]) mem_q[idx][8*b +: 8] <= DRAM_D[8*b +: 8];
      end
    end
  end

  assign DRAM_Q     = rd_data_q[CL-1];
  assign DRAM_valid = rd_vld_q[CL-1];
  assign DRAM_err   = err_q;

endmodule

// File: tb/tb_dram_device_model.sv
// Directed bench for dram_device_model: read/write, byte masks, bursts, timing
// violations and reset behaviour with CL=3, tRCD=tRP=2.
module tb_dram_device_model;

  logic        clk = 1'b0;
  logic        rst;
  logic        csn, rasn, casn;
  logic [3:0]  wen;
  logic [10:0] a;
  logic [31:0] d;
  logic [31:0] q;
  logic        vld, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dram_device_model #(.T_RCD(2), .T_RP(2), .CL(3), .MEM_ADDR_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .DRAM_CSn  (csn),
    .DRAM_RASn (rasn),
    .DRAM_CASn (casn),
    .DRAM_WEn  (wen),
    .DRAM_A    (a),
    .DRAM_D    (d),
    .DRAM_Q    (q),
    .DRAM_valid(vld),
    .DRAM_err  (err)
  );

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] eq, input logic ee);
    ck({tag, "_valid"}, {31'd0, vld}, {31'd0, ev});
    ck({tag, "_q"}, q, eq);
    ck({tag, "_err"}, {31'd0, err}, {31'd0, ee});
  endtask

  task automatic chk_v(input string tag, input logic ev);
    ck({tag, "_valid"}, {31'd0, vld}, {31'd0, ev});
  endtask

  task automatic cmd(input logic c, input logic r, input logic s, input logic [3:0] w,
                     input logic [10:0] ad, input logic [31:0] dd);
    csn = c; rasn = r; casn = s; wen = w; a = ad; d = dd;
  endtask

  task automatic nop();                    cmd(1'b1, 1'b1, 1'b1, 4'hF, 11'd0, 32'd0); endtask
  task automatic act(input logic [10:0] r); cmd(1'b0, 1'b0, 1'b1, 4'hF, r, 32'd0);    endtask
  task automatic pre();                    cmd(1'b0, 1'b1, 1'b1, 4'hF, 11'd0, 32'd0); endtask
  task automatic rd(input logic [9:0] c);  cmd(1'b0, 1'b0, 1'b0, 4'hF, {1'b0, c}, 32'd0); endtask
  task automatic wr(input logic [9:0] c, input logic [3:0] w, input logic [31:0] dd);
    cmd(1'b0, 1'b0, 1'b0, w, {1'b0, c}, dd);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    nop();
    repeat (3) nxt();

    // write, read, byte-masked write, read
    chk_out("reset", 1'b0, 32'h0, 1'b0); rst = 1'b0; act(11'h005);   // c0
    nxt(); nop();                                                    // c1
    nxt(); wr(10'h010, 4'h0, 32'hDEADBEEF);                          // c2
    nxt(); rd(10'h010);                                              // c3
    nxt(); chk_v("c4", 1'b0); wr(10'h010, 4'b1100, 32'h00001234);    // c4
    nxt(); chk_v("c5", 1'b0); rd(10'h010);                           // c5
    nxt(); chk_out("wr_rd", 1'b1, 32'hDEADBEEF, 1'b0); wr(10'h020, 4'h0, 32'd1); // c6
    nxt(); chk_out("gap", 1'b0, 32'hDEADBEEF, 1'b0); wr(10'h021, 4'h0, 32'd2);   // c7
    nxt(); chk_out("bytemask", 1'b1, 32'hDEAD1234, 1'b0); wr(10'h022, 4'h0, 32'd3); // c8
    nxt(); chk_v("c9", 1'b0); wr(10'h023, 4'h0, 32'd4);              // c9

    // back-to-back reads
    nxt(); rd(10'h020);                                              // c10
    nxt(); rd(10'h021);                                              // c11
    nxt(); chk_v("c12", 1'b0); rd(10'h022);                          // c12
    nxt(); chk_out("burst0", 1'b1, 32'd1, 1'b0); rd(10'h023);        // c13
    nxt(); chk_out("burst1", 1'b1, 32'd2, 1'b0); nop();              // c14
    nxt(); chk_out("burst2", 1'b1, 32'd3, 1'b0);                     // c15
    nxt(); chk_out("burst3", 1'b1, 32'd4, 1'b0);                     // c16
    nxt(); chk_out("burst_hold", 1'b0, 32'd4, 1'b0);                 // c17

    // tRCD violation
    nxt(); pre();                                                    // c18
    nxt(); nop();                                                    // c19
    nxt(); act(11'h005);                                             // c20
    nxt(); rd(10'h020);                                              // c21 illegal
    nxt(); chk_out("trcd_err", 1'b0, 32'd4, 1'b1); rd(10'h021);      // c22 legal
    nxt(); chk_v("c23", 1'b0); nop();                                // c23
    nxt(); chk_out("trcd_no_vld", 1'b0, 32'd4, 1'b1);                // c24
    nxt(); chk_out("trcd_legal_rd", 1'b1, 32'd2, 1'b1);              // c25
    nxt(); chk_out("err_sticky", 1'b0, 32'd2, 1'b1); rst = 1'b1;     // c26

    // tRP violation
    nxt(); rst = 1'b0; chk_out("rst2", 1'b0, 32'h0, 1'b0); act(11'h005); // d0
    nxt(); nop();                                                    // d1
    nxt(); pre();                                                    // d2
    nxt(); act(11'h7FF);                                             // d3 illegal
    nxt(); chk_out("trp_err", 1'b0, 32'h0, 1'b1); rd(10'h020);       // d4 illegal, IDLE
    nxt(); nop();                                                    // d5
    nxt();                                                           // d6
    nxt(); chk_out("trp_no_vld", 1'b0, 32'h0, 1'b1); rst = 1'b1;     // d7

    // legal PRE -> ACT 0x7FF after reset
    nxt(); rst = 1'b0; chk_out("rst3", 1'b0, 32'h0, 1'b0); pre();    // e0
    nxt(); nop();                                                    // e1
    nxt(); act(11'h7FF);                                             // e2
    nxt(); nop();                                                    // e3
    nxt(); wr(10'h010, 4'h0, 32'h11112222);                          // e4
    nxt(); rd(10'h010);                                              // e5
    nxt(); nop();                                                    // e6
    nxt();                                                           // e7
    nxt(); chk_out("row7ff", 1'b1, 32'h11112222, 1'b0); pre();       // e8
    nxt(); nop();                                                    // e9
    nxt();                                                           // e10
    nxt(); act(11'h005);                                             // e11
    nxt(); nop();                                                    // e12
    nxt(); rd(10'h010);                                              // e13
    nxt(); rd(10'h020);                                              // e14
    nxt(); rst = 1'b1; nop();                                        // e15

    // reset mid-read drops in-flight reads, memory preserved
    nxt(); rst = 1'b0; chk_out("midrd0", 1'b0, 32'h0, 1'b0); act(11'h005); // f0
    nxt(); chk_out("midrd1", 1'b0, 32'h0, 1'b0); nop();              // f1
    nxt(); chk_out("midrd2", 1'b0, 32'h0, 1'b0); rd(10'h010);        // f2
    nxt(); rd(10'h023);                                              // f3
    nxt(); nop();                                                    // f4
    nxt(); chk_out("preserved0", 1'b1, 32'hDEAD1234, 1'b0);          // f5
    nxt(); chk_out("preserved1", 1'b1, 32'd4, 1'b0);                 // f6
    nxt(); chk_out("final_hold", 1'b0, 32'd4, 1'b0);                 // f7

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
